// File: rtl/hex_scan_driver.sv
// Time-multiplexed scan driver for an N-digit common-anode 7-segment display.
// Optional build macro: LEAD_ZERO_BLANK_EN (suppress leading zero digits).
module hex_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank,
  output logic [3:0]              nibble,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    pending,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      shadow_q, shadow_d;
  logic [VAL_W-1:0]      disp_q, disp_d;
  logic                  pending_q, pending_d;
  logic [3:0]            nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0] digit_en_n_q, digit_en_n_d;
  logic                  frame_tick_q, frame_tick_d;

  logic slot_end;
  logic frame_end;
  logic lead_zero;

  // Slot counter, digit index and double-buffered display value
  always_comb begin
    slot_end  = (div_cnt_q == DIV_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);

    div_cnt_d = slot_end ? '0 : div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    shadow_d  = shadow_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end
    // A load landing on the commit cycle bypasses the shadow straight to disp
    if (frame_end) begin
      pending_d = 1'b0;
      if (load) begin
        disp_d = value;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
    end
  end

  // Registered display outputs, one cycle behind idx/disp
  always_comb begin
    nibble_d     = 4'h0;
    digit_en_n_d = '1;
    lead_zero    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nibble_d        = disp_q[4*k +: 4];
        digit_en_n_d[k] = 1'b0;
      end
    end
`ifdef LEAD_ZERO_BLANK_EN
    // Digit k>0 is dark when it and every more significant digit are zero
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if ((idx_q == IDX_W'(k)) && ((disp_q >> (4*k)) == '0)) begin
        lead_zero = 1'b1;
      end
    end
`else
    lead_zero = 1'b0;
`endif
    if (blank || lead_zero) begin
      digit_en_n_d = '1;
    end
    frame_tick_d = frame_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      nibble_q     <= 4'h0;
      digit_en_n_q <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      nibble_q     <= nibble_d;
      digit_en_n_q <= digit_en_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign nibble     = nibble_q;
  assign digit_en_n = digit_en_n_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed table-driven bench for hex_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4).
module tb_hex_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic        blank = 1'b0;
  logic [3:0]  nibble;
  logic [3:0]  digit_en_n;
  logic        pending;
  logic        frame_tick;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          c;
    logic        ld;
    logic [15:0] val;
    logic        blk;
    logic [3:0]  nib;
    logic [3:0]  en;
    logic        pend;
    logic        tick;
  } vec_t;

  vec_t tbl1[$];
  vec_t tbl2[$];

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [3:0] EN1 = 4'b1111;
  localparam logic [3:0] EN2 = 4'b1111;
  localparam logic [3:0] EN3 = 4'b1111;
`else
  localparam logic [3:0] EN1 = 4'b1101;
  localparam logic [3:0] EN2 = 4'b1011;
  localparam logic [3:0] EN3 = 4'b0111;
`endif

  hex_scan_driver #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .DIV_W      (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .value     (value),
    .blank     (blank),
    .nibble    (nibble),
    .digit_en_n(digit_en_n),
    .pending   (pending),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(int c, logic ld, logic [15:0] val, logic blk, logic [3:0] nib,
                             logic [3:0] en, logic pend, logic tick);
    vec_t r;
    r.c = c; r.ld = ld; r.val = val; r.blk = blk;
    r.nib = nib; r.en = en; r.pend = pend; r.tick = tick;
    return r;
  endfunction

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all(logic [3:0] nib, logic [3:0] en, logic pend, logic tick);
    chk("nibble", nibble, nib);
    chk("digit_en_n", digit_en_n, en);
    chk("pending", {3'b0, pending}, {3'b0, pend});
    chk("frame_tick", {3'b0, frame_tick}, {3'b0, tick});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance to the record's cycle, drive its inputs for that cycle, check outputs
  task automatic run_vec(vec_t r);
    while (cyc < r.c) begin
      step();
      load  = 1'b0;
      blank = 1'b0;
    end
    load  = r.ld;
    value = r.val;
    blank = r.blk;
    #1;
    chk_all(r.nib, r.en, r.pend, r.tick);
  endtask

  initial begin
    // Load, commit, scan order, double-buffering, bypass load, blanking
    tbl1.push_back(v(0,  0, 16'h0,    0, 4'h0, 4'b1111, 0, 0));
    tbl1.push_back(v(1,  0, 16'h0,    0, 4'h0, 4'b1110, 0, 0));
    tbl1.push_back(v(2,  1, 16'h12AB, 0, 4'h0, 4'b1110, 0, 0));
    tbl1.push_back(v(3,  0, 16'h0,    0, 4'h0, 4'b1110, 1, 0));
    tbl1.push_back(v(5,  0, 16'h0,    0, 4'h0, 4'b1101, 1, 0));
    tbl1.push_back(v(15, 0, 16'h0,    0, 4'h0, 4'b0111, 1, 0));
    tbl1.push_back(v(16, 0, 16'h0,    0, 4'h0, 4'b0111, 0, 1));
    tbl1.push_back(v(17, 0, 16'h0,    0, 4'hB, 4'b1110, 0, 0));
    tbl1.push_back(v(20, 0, 16'h0,    0, 4'hB, 4'b1110, 0, 0));
    tbl1.push_back(v(21, 0, 16'h0,    0, 4'hA, 4'b1101, 0, 0));
    tbl1.push_back(v(25, 0, 16'h0,    0, 4'h2, 4'b1011, 0, 0));
    tbl1.push_back(v(29, 0, 16'h0,    0, 4'h1, 4'b0111, 0, 0));
    tbl1.push_back(v(32, 0, 16'h0,    0, 4'h1, 4'b0111, 0, 1));
    tbl1.push_back(v(33, 0, 16'h0,    0, 4'hB, 4'b1110, 0, 0));
    tbl1.push_back(v(34, 1, 16'h1111, 0, 4'hB, 4'b1110, 0, 0));
    tbl1.push_back(v(40, 1, 16'h2222, 0, 4'hA, 4'b1101, 1, 0));
    tbl1.push_back(v(41, 0, 16'h0,    0, 4'h2, 4'b1011, 1, 0));
    tbl1.push_back(v(48, 0, 16'h0,    0, 4'h1, 4'b0111, 0, 1));
    tbl1.push_back(v(49, 0, 16'h0,    0, 4'h2, 4'b1110, 0, 0));
    tbl1.push_back(v(53, 0, 16'h0,    0, 4'h2, 4'b1101, 0, 0));
    tbl1.push_back(v(63, 1, 16'h5A5A, 0, 4'h2, 4'b0111, 0, 0));
    tbl1.push_back(v(64, 0, 16'h0,    0, 4'h2, 4'b0111, 0, 1));
    tbl1.push_back(v(65, 0, 16'h0,    0, 4'hA, 4'b1110, 0, 0));
    tbl1.push_back(v(69, 0, 16'h0,    0, 4'h5, 4'b1101, 0, 0));
    tbl1.push_back(v(70, 0, 16'h0,    1, 4'h5, 4'b1101, 0, 0));
    tbl1.push_back(v(71, 0, 16'h0,    1, 4'h5, 4'b1111, 0, 0));
    tbl1.push_back(v(72, 0, 16'h0,    1, 4'h5, 4'b1111, 0, 0));
    tbl1.push_back(v(73, 0, 16'h0,    1, 4'hA, 4'b1111, 0, 0));
    tbl1.push_back(v(74, 0, 16'h0,    1, 4'hA, 4'b1111, 0, 0));
    tbl1.push_back(v(75, 0, 16'h0,    1, 4'hA, 4'b1111, 0, 0));
    tbl1.push_back(v(76, 0, 16'h0,    0, 4'hA, 4'b1111, 0, 0));
    tbl1.push_back(v(77, 0, 16'h0,    0, 4'h5, 4'b0111, 0, 0));
    tbl1.push_back(v(80, 0, 16'h0,    0, 4'h5, 4'b0111, 0, 1));
    tbl1.push_back(v(81, 0, 16'h0,    0, 4'hA, 4'b1110, 0, 0));

    // Leading-zero handling after a fresh reset (expectations depend on the build)
    tbl2.push_back(v(3,  1, 16'h00A0, 0, 4'h0, 4'b1110, 0, 0));
    tbl2.push_back(v(16, 0, 16'h0,    0, 4'h0, EN3,     0, 1));
    tbl2.push_back(v(17, 0, 16'h0,    0, 4'h0, 4'b1110, 0, 0));
    tbl2.push_back(v(21, 0, 16'h0,    0, 4'hA, 4'b1101, 0, 0));
    tbl2.push_back(v(22, 1, 16'h0000, 0, 4'hA, 4'b1101, 0, 0));
    tbl2.push_back(v(23, 0, 16'h0,    0, 4'hA, 4'b1101, 1, 0));
    tbl2.push_back(v(25, 0, 16'h0,    0, 4'h0, EN2,     1, 0));
    tbl2.push_back(v(29, 0, 16'h0,    0, 4'h0, EN3,     1, 0));
    tbl2.push_back(v(32, 0, 16'h0,    0, 4'h0, EN3,     0, 1));
    tbl2.push_back(v(33, 0, 16'h0,    0, 4'h0, 4'b1110, 0, 0));
    tbl2.push_back(v(37, 0, 16'h0,    0, 4'h0, EN1,     0, 0));
    tbl2.push_back(v(41, 0, 16'h0,    0, 4'h0, EN2,     0, 0));
    tbl2.push_back(v(45, 0, 16'h0,    0, 4'h0, EN3,     0, 0));

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    foreach (tbl1[i]) run_vec(tbl1[i]);

    // Asynchronous reset mid-slot while a load is pending
    step();
    load  = 1'b1;
    value = 16'h3333;
    blank = 1'b0;
    step();
    load = 1'b0;
    chk("pending_before_rst", {3'b0, pending}, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all(4'h0, 4'b1111, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    chk_all(4'h0, 4'b1111, 1'b0, 1'b0);
    step();
    chk_all(4'h0, 4'b1110, 1'b0, 1'b0);
    step();
    chk_all(4'h0, 4'b1110, 1'b0, 1'b0);

    foreach (tbl2[i]) run_vec(tbl2[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
